color_bounce_update: RTL and testbench

- Per-frame game-logic stage of the colour-bounce game; sits directly upstream of the game-state register bank.
- Samples current state (ball height, ball colour, platform colours/positions, score) on each frame tick and runs a short multi-cycle sequence:
  - ball motion
  - platform scroll and recolour
  - collision and colour-match check
  - BCD score update
- Presents next-state values with a one-cycle valid strobe for the register bank to capture.

---
 rtl/color_bounce_update.sv | 145 ++++++++++++++
 tb/tb_color_bounce_update.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/color_bounce_update.sv
// color_bounce_update: per-frame ball motion, platform scroll, collision and BCD score update.
// Define COLOR_BOUNCE_LIVES_EN to enable the three-life respawn counter.
module color_bounce_update #(
    parameter int BALL_X = 20,
    parameter int PLAT_W = 16,
    parameter int JUMP_H = 40,
    parameter int SCROLL = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic [7:0]  curr_ball_in,
    input  logic [2:0]  color_ball_in,
    input  logic [11:0] color_plats_in,
    input  logic [27:0] position_plats_in,
    input  logic [11:0] score_in,
    input  logic [2:0]  color_sel,
    input  logic        color_load,
    output logic [7:0]  prev_ball_out,
    output logic [7:0]  curr_ball_out,
    output logic [2:0]  color_ball_out,
    output logic [11:0] color_plats_out,
    output logic [27:0] position_plats_out,
    output logic [11:0] score_out,
    output logic        out_valid,
    output logic        game_over,
    output logic [1:0]  lives_out
);
    typedef enum logic [2:0] {
        IDLE = 3'd0, MOVE = 3'd1, RESOLVE = 3'd2, DONE = 3'd3,
        SCAN0 = 3'd4, SCAN1 = 3'd5, SCAN2 = 3'd6, SCAN3 = 3'd7
    } state_t;
    state_t state;
    logic [7:0] lfsr, h, h_prev, n_h;
    logic [3:0][6:0] xs;
    logic [3:0][2:0] cs;
    logic [2:0] bc, hit_c, pend_c, wrap_c;
    logic [11:0] sc, sc_inc, n_sc;
    logic [6:0] dx;
    logic falling, at_floor, hit_v, pend_v, hit_now, match, miss, n_fall, n_over;
    // Scan states carry the platform index in their low two bits.
    assign dx = 7'(BALL_X) - xs[state[1:0]];
    assign hit_now = dx < 7'(PLAT_W);
    assign wrap_c = lfsr[2:0] == 3'd0 ? 3'b111 : lfsr[2:0];
    assign match = at_floor && hit_v && hit_c == bc;
    assign miss = at_floor && !match;
    assign sc_inc = sc == 12'h999 ? sc :
                    sc[3:0] != 4'h9 ? {sc[11:4], sc[3:0] + 4'd1} :
                    sc[7:4] != 4'h9 ? {sc[11:8], sc[7:4] + 4'd1, 4'h0} :
                    {sc[11:8] + 4'd1, 8'h00};
    assign n_sc = match ? sc_inc : sc;
`ifdef COLOR_BOUNCE_LIVES_EN
    logic [1:0] lives;
    assign lives_out = lives;
    assign n_h = miss ? 8'(JUMP_H) : h;
    assign n_fall = miss | (falling & ~match);
    assign n_over = game_over | (miss && lives == 2'd1);
    always_ff @(posedge clk) begin
        if (!reset) lives <= 2'd3;
        else if (state == RESOLVE && miss) lives <= lives - 2'd1;
    end
`else
    assign lives_out = 2'd0;
    assign n_h = h;
    assign n_fall = falling & ~match;
    assign n_over = game_over | miss;
`endif
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            lfsr <= 8'h01;
            out_valid <= 1'b0;
            game_over <= 1'b0;
            falling <= 1'b0;
            pend_v <= 1'b0;
            pend_c <= 3'd0;
            prev_ball_out <= 8'd0;
            curr_ball_out <= 8'd0;
            score_out <= 12'h000;
            color_ball_out <= 3'b111;
            color_plats_out <= 12'b001110111101;
            position_plats_out <= 28'b0100011011110010101011101110;
            h <= 8'd0;
            h_prev <= 8'd0;
            xs <= '0;
            cs <= '0;
            bc <= 3'd0;
            sc <= 12'h000;
            at_floor <= 1'b0;
            hit_v <= 1'b0;
            hit_c <= 3'd0;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            out_valid <= 1'b0;
            if (color_load && color_sel != 3'd0) begin
                pend_v <= 1'b1;
                pend_c <= color_sel;
            end else if (state == RESOLVE) pend_v <= 1'b0;
            case (state)
                IDLE: if (tick && !game_over) begin
                    h <= curr_ball_in;
                    bc <= color_ball_in;
                    cs <= color_plats_in;
                    xs <= position_plats_in;
                    sc <= score_in;
                    hit_v <= 1'b0;
                    state <= MOVE;
                end
                MOVE: begin
                    h_prev <= h;
                    if (!falling) begin
                        h <= h + 8'd1;
                        if (h + 8'd1 >= 8'(JUMP_H)) falling <= 1'b1;
                    end else if (h != 8'd0) h <= h - 8'd1;
                    at_floor <= falling && h == 8'd0;
                    for (int i = 0; i < 4; i++) begin
                        xs[i] <= xs[i] - 7'(SCROLL);
                        if (xs[i] < 7'(SCROLL)) cs[i] <= wrap_c;
                    end
                    state <= SCAN0;
                end
                RESOLVE: begin
                    falling <= n_fall;
                    game_over <= n_over;
                    prev_ball_out <= h_prev;
                    curr_ball_out <= n_h;
                    color_ball_out <= pend_v ? pend_c : bc;
                    color_plats_out <= cs;
                    position_plats_out <= xs;
                    score_out <= n_sc;
                    out_valid <= 1'b1;
                    state <= DONE;
                end
                DONE: state <= IDLE;
                default: begin
                    if (at_floor && !hit_v && hit_now) begin
                        hit_v <= 1'b1;
                        hit_c <= cs[state[1:0]];
                    end
                    state <= state == SCAN3 ? RESOLVE : state_t'(state + 3'd1);
                end
            endcase
        end
    end
endmodule

// File: tb/tb_color_bounce_update.sv
// tb_color_bounce_update: directed frame vectors plus multi-cycle corner sequences.
module tb_color_bounce_update;
`ifdef COLOR_BOUNCE_LIVES_EN
    localparam bit LV = 1'b1;
`else
    localparam bit LV = 1'b0;
`endif
    localparam logic [11:0] CPA = 12'b001110111101;
    localparam logic [27:0] RP = 28'b0100011011110010101011101110;

    logic clk = 1'b0, reset = 1'b0, tick = 1'b0, color_load = 1'b0;
    logic [2:0] color_sel = 3'd0, color_ball_in = 3'd0;
    logic [7:0] curr_ball_in = 8'd0;
    logic [11:0] color_plats_in = 12'd0, score_in = 12'd0;
    logic [27:0] position_plats_in = 28'd0;
    logic [7:0] prev_ball_out, curr_ball_out;
    logic [2:0] color_ball_out;
    logic [11:0] color_plats_out, score_out;
    logic [27:0] position_plats_out;
    logic out_valid, game_over;
    logic [1:0] lives_out;

    always #5 clk = ~clk;

    color_bounce_update dut (
        .clk(clk), .reset(reset), .tick(tick),
        .curr_ball_in(curr_ball_in), .color_ball_in(color_ball_in),
        .color_plats_in(color_plats_in), .position_plats_in(position_plats_in),
        .score_in(score_in), .color_sel(color_sel), .color_load(color_load),
        .prev_ball_out(prev_ball_out), .curr_ball_out(curr_ball_out),
        .color_ball_out(color_ball_out), .color_plats_out(color_plats_out),
        .position_plats_out(position_plats_out), .score_out(score_out),
        .out_valid(out_valid), .game_over(game_over), .lives_out(lives_out)
    );

    typedef struct {
        logic        rst;
        logic [7:0]  ball;
        logic [2:0]  bcol;
        logic [11:0] cp;
        logic [27:0] pos;
        logic [11:0] sc;
        logic [7:0]  e_prev, e_curr;
        logic [11:0] e_cp, cmask;
        logic [27:0] e_pos;
        logic [11:0] e_sc;
        logic        e_over;
        logic [1:0]  e_lives;
        logic        wrap0;
    } vec_t;

    vec_t tv[15];
    int n_chk = 0, n_err = 0, strobes = 0;

    always @(negedge clk) if (out_valid) strobes++;

    function automatic logic [27:0] pk(input int a3, input int a2, input int a1, input int a0);
        return {7'(a3), 7'(a2), 7'(a1), 7'(a0)};
    endfunction

    function automatic logic [11:0] ck(input int c3, input int c2, input int c1, input int c0);
        return {3'(c3), 3'(c2), 3'(c1), 3'(c0)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        tick = 1'b0;
        color_load = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " out_valid"}, out_valid, 0);
        chk({tag, " game_over"}, game_over, 0);
        chk({tag, " prev"}, prev_ball_out, 0);
        chk({tag, " curr"}, curr_ball_out, 0);
        chk({tag, " ball colour"}, color_ball_out, 3'b111);
        chk({tag, " plat colours"}, color_plats_out, CPA);
        chk({tag, " plat positions"}, position_plats_out, RP);
        chk({tag, " score"}, score_out, 0);
        chk({tag, " lives"}, lives_out, LV ? 2'd3 : 2'd0);
    endtask

    task automatic run_vec(input vec_t v, input int k);
        int lat;
        if (v.rst) do_reset();
        @(negedge clk);
        curr_ball_in = v.ball;
        color_ball_in = v.bcol;
        color_plats_in = v.cp;
        position_plats_in = v.pos;
        score_in = v.sc;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("v%0d latency", k), lat, 7);
        chk($sformatf("v%0d prev", k), prev_ball_out, v.e_prev);
        chk($sformatf("v%0d curr", k), curr_ball_out, v.e_curr);
        chk($sformatf("v%0d ball colour", k), color_ball_out, v.bcol);
        chk($sformatf("v%0d plat colours", k), color_plats_out & v.cmask, v.e_cp & v.cmask);
        chk($sformatf("v%0d plat positions", k), position_plats_out, v.e_pos);
        chk($sformatf("v%0d score", k), score_out, v.e_sc);
        chk($sformatf("v%0d game_over", k), game_over, v.e_over);
        chk($sformatf("v%0d lives", k), lives_out, v.e_lives);
        if (v.wrap0) chk($sformatf("v%0d wrapped colour nonzero", k), color_plats_out[2:0] != 3'd0, 1);
    endtask

    initial begin
        logic [1:0] l3, l2;
        logic [7:0] mc;
        logic [27:0] rps;
        logic [11:0] c3;
        logic [27:0] p3;
        l3 = LV ? 2'd3 : 2'd0;
        l2 = LV ? 2'd2 : 2'd0;
        mc = LV ? 8'd40 : 8'd0;
        rps = pk(34, 59, 84, 109);
        c3 = ck(1, 6, 2, 7);
        p3 = pk(50, 100, 70, 10);
        tv[0]  = '{1'b0, 8'd5,  3'd7, CPA, RP, 12'h000, 8'd5,  8'd6,  CPA, 12'hFFF, rps, 12'h000, 1'b0, l3, 1'b0};
        tv[1]  = '{1'b0, 8'd39, 3'd7, CPA, RP, 12'h123, 8'd39, 8'd40, CPA, 12'hFFF, rps, 12'h123, 1'b0, l3, 1'b0};
        tv[2]  = '{1'b0, 8'd40, 3'd7, CPA, RP, 12'h045, 8'd40, 8'd39, CPA, 12'hFFF, rps, 12'h045, 1'b0, l3, 1'b0};
        tv[3]  = '{1'b0, 8'd0, 3'd7, c3, p3, 12'h099, 8'd0, 8'd0, c3, 12'hFFF, pk(49, 99, 69, 9), 12'h100, 1'b0, l3, 1'b0};
        tv[4]  = '{1'b0, 8'd0, 3'd7, c3, p3, 12'h100, 8'd0, 8'd1, c3, 12'hFFF, pk(49, 99, 69, 9), 12'h100, 1'b0, l3, 1'b0};
        tv[5]  = '{1'b0, 8'd39, 3'd7, CPA, RP, 12'h000, 8'd39, 8'd40, CPA, 12'hFFF, rps, 12'h000, 1'b0, l3, 1'b0};
        tv[6]  = '{1'b0, 8'd0, 3'd7, ck(3, 2, 7, 4), pk(100, 20, 15, 60), 12'h009, 8'd0, 8'd0,
                   ck(3, 2, 7, 4), 12'hFFF, pk(99, 19, 14, 59), 12'h010, 1'b0, l3, 1'b0};
        tv[7]  = tv[5];
        tv[8]  = '{1'b0, 8'd0, 3'd7, c3, pk(50, 100, 70, 6), 12'h999, 8'd0, 8'd0, c3, 12'hFFF,
                   pk(49, 99, 69, 5), 12'h999, 1'b0, l3, 1'b0};
        tv[9]  = tv[5];
        tv[10] = '{1'b0, 8'd0, 3'd7, ck(1, 6, 7, 3), pk(50, 100, 21, 0), 12'h019, 8'd0, 8'd0,
                   ck(1, 6, 7, 3), 12'hFF8, pk(49, 99, 20, 127), 12'h020, 1'b0, l3, 1'b1};
        tv[11] = tv[5];
        tv[12] = '{1'b0, 8'd0, 3'd7, ck(1, 6, 2, 5), p3, 12'h050, 8'd0, mc, ck(1, 6, 2, 5), 12'hFFF,
                   pk(49, 99, 69, 9), 12'h050, !LV, l2, 1'b0};
        tv[13] = tv[5];
        tv[13].rst = 1'b1;
        tv[14] = '{1'b0, 8'd0, 3'd7, ck(7, 7, 7, 7), pk(50, 100, 70, 5), 12'h300, 8'd0, mc, ck(7, 7, 7, 7),
                   12'hFFF, pk(49, 99, 69, 4), 12'h300, !LV, l2, 1'b0};

        do_reset();
        @(negedge clk);
        check_reset("reset");
        for (int k = 0; k < 15; k++) run_vec(tv[k], k);

        // A tick after a miss: ignored once game_over is set, accepted while lives remain.
        @(negedge clk);
        strobes = 0;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        repeat (15) @(negedge clk);
        chk("tick after miss strobes", strobes, LV ? 1 : 0);
        chk("game_over sticky", game_over, !LV);

        do_reset();
        @(negedge clk);
        check_reset("re-reset");

        // Extra tick during SCAN1 plus pending colour loads mid-frame.
        curr_ball_in = 8'd5;
        color_ball_in = 3'd7;
        color_plats_in = CPA;
        position_plats_in = RP;
        score_in = 12'h042;
        strobes = 0;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tick = 1'b1;
        color_load = 1'b1;
        color_sel = 3'b011;
        @(negedge clk);
        tick = 1'b0;
        color_sel = 3'b000;
        @(negedge clk);
        color_load = 1'b0;
        repeat (15) @(negedge clk);
        chk("mid tick strobes", strobes, 1);
        chk("pending colour applied", color_ball_out, 3'b011);
        chk("mid tick prev", prev_ball_out, 5);
        chk("mid tick curr", curr_ball_out, 6);
        chk("mid tick score", score_out, 12'h042);

        // Reset during a frame must not strobe and must restore reset outputs.
        @(negedge clk);
        strobes = 0;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (15) @(negedge clk);
        chk("mid reset strobes", strobes, 0);
        check_reset("mid reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
